// File: rtl/brick_row.sv
// Row of NUM_BRICKS bricks sharing one descending y, with a sequential ball/brick overlap scan.
// Optional macro BRICK_ROW_MULTIHIT_EN gives each brick INIT_HP hit points instead of one.
module brick_row #(
  parameter int  NUM_BRICKS = 8,
  parameter int  COORD_W    = 10,
  parameter int  BRICK_W    = 57,
  parameter int  BRICK_H    = 19,
  parameter int  GAP        = 3,
  parameter int  BALL_SIZE  = 20,
  parameter int  FLOOR_Y    = 458,
  parameter int  STEP       = 1,
  parameter int  HP_W       = 2,
  parameter int  INIT_HP    = 3,
  localparam int IDX_W      = (NUM_BRICKS > 1) ? $clog2(NUM_BRICKS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [COORD_W-1:0]    init_x,
  input  logic [COORD_W-1:0]    init_y,
  input  logic [COORD_W-1:0]    ball_x,
  input  logic [COORD_W-1:0]    ball_y,
  input  logic                  ball_valid,
  input  logic [24:0]           delay_done,
  output logic [COORD_W-1:0]    row_y,
  output logic [NUM_BRICKS-1:0] alive,
  output logic                  busy,
  output logic                  hit_pulse,
  output logic [IDX_W-1:0]      hit_idx,
  output logic                  cleared,
  output logic                  game_over
);

  localparam int XW     = COORD_W + 7;
  localparam int CW     = COORD_W + 8;
  localparam int STRIDE = BRICK_W + GAP;

  typedef enum logic [1:0] {S_WAIT, S_SCAN, S_HIT, S_DONE} state_t;

  if (NUM_BRICKS < 1 || NUM_BRICKS > 64 || INIT_HP < 1 || INIT_HP >= (1 << HP_W)) begin : g_bad_param
    $error("brick_row: NUM_BRICKS or INIT_HP out of range");
  end

  state_t                r_state;
  logic [COORD_W-1:0]    r_row_y;
  logic [COORD_W-1:0]    r_ball_x;
  logic [COORD_W-1:0]    r_ball_y;
  logic [NUM_BRICKS-1:0] r_alive;
  logic                  r_busy;
  logic                  r_hit_pulse;
  logic [IDX_W-1:0]      r_hit_idx;
  logic [IDX_W-1:0]      r_k;
  logic                  r_cleared;
  logic                  r_game_over;
  logic [24:0]           r_cnt;

  logic [XW-1:0]         w_brick_x;
  logic [CW-1:0]         w_lx;
  logic [CW-1:0]         w_bx;
  logic [CW-1:0]         w_ly;
  logic [CW-1:0]         w_ry;
  logic                  w_ovl;
  logic                  w_at_floor;
  logic                  w_last_k;
  logic                  w_kill;

  // Only the brick under test needs its x, so one multiplier serves the whole row.
  assign w_brick_x  = XW'(init_x) + XW'(r_k) * XW'(STRIDE);
  assign w_lx       = CW'(w_brick_x);
  assign w_bx       = CW'(r_ball_x);
  assign w_ly       = CW'(r_ball_y);
  assign w_ry       = CW'(r_row_y);
  assign w_ovl      = (w_bx <= w_lx + CW'(BRICK_W)) && (w_lx + CW'(BALL_SIZE) >= w_bx) &&
                      (w_ly <= w_ry + CW'(BRICK_H)) && (w_ly + CW'(BALL_SIZE) >= w_ry);
  assign w_at_floor = (w_ry + CW'(BRICK_H) >= CW'(FLOOR_Y));
  assign w_last_k   = (r_k == IDX_W'(NUM_BRICKS - 1));

`ifdef BRICK_ROW_MULTIHIT_EN
  logic [HP_W-1:0] r_hp [NUM_BRICKS];
  assign w_kill = (r_hp[r_k] <= HP_W'(1));
`else
  assign w_kill = 1'b1;
`endif

  // NOTE: all state is updated with non-blocking assignments so every read sees the pre-edge value.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_WAIT;
      r_row_y     <= init_y;
      r_ball_x    <= '0;
      r_ball_y    <= '0;
      r_alive     <= '1;
      r_busy      <= 1'b0;
      r_hit_pulse <= 1'b0;
      r_hit_idx   <= '0;
      r_k         <= '0;
      r_cleared   <= 1'b0;
      r_game_over <= 1'b0;
      r_cnt       <= '0;
`ifdef BRICK_ROW_MULTIHIT_EN
      // NOTE: the hp array is reset explicitly because bricks must start every game at INIT_HP.
      for (int i = 0; i < NUM_BRICKS; i++) r_hp[i] <= HP_W'(INIT_HP);
`endif
    end else begin
      r_hit_pulse <= 1'b0;

      // Descent timer: a pending step waits for the next WAIT cycle.
      if (r_state == S_WAIT) begin
        if (r_cnt >= delay_done) begin
          r_cnt <= '0;
          if (!w_at_floor) r_row_y <= r_row_y + COORD_W'(STEP);
        end else begin
          r_cnt <= r_cnt + 25'd1;
        end
      end else if (r_state != S_DONE) begin
        r_cnt <= (r_cnt >= delay_done) ? delay_done : r_cnt + 25'd1;
      end

      case (r_state)
        S_WAIT: begin
          if (ball_valid && !r_cleared && !r_game_over) begin
            r_ball_x <= ball_x;
            r_ball_y <= ball_y;
            r_k      <= '0;
            r_busy   <= 1'b1;
            r_state  <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (w_ovl && r_alive[r_k]) begin
            r_state     <= S_HIT;
            r_hit_pulse <= 1'b1;
            r_hit_idx   <= r_k;
          end else if (w_last_k) begin
            r_state <= S_WAIT;
            r_busy  <= 1'b0;
          end else begin
            r_k <= r_k + IDX_W'(1);
          end
        end
        S_HIT: begin
          if (w_kill) r_alive[r_k] <= 1'b0;
`ifdef BRICK_ROW_MULTIHIT_EN
          r_hp[r_k] <= r_hp[r_k] - HP_W'(1);
`endif
          r_state <= S_WAIT;
          r_busy  <= 1'b0;
        end
        default: begin
        end
      endcase

      // End-of-game detection overrides the scan; an empty row counts as cleared, not landed.
      if (r_state != S_DONE) begin
        if (r_alive == '0) begin
          r_cleared   <= 1'b1;
          r_state     <= S_DONE;
          r_busy      <= 1'b0;
          r_hit_pulse <= 1'b0;
        end else if (w_at_floor) begin
          r_game_over <= 1'b1;
          r_state     <= S_DONE;
          r_busy      <= 1'b0;
          r_hit_pulse <= 1'b0;
        end
      end
    end
  end

  assign row_y     = r_row_y;
  assign alive     = r_alive;
  assign busy      = r_busy;
  assign hit_pulse = r_hit_pulse;
  assign hit_idx   = r_hit_idx;
  assign cleared   = r_cleared;
  assign game_over = r_game_over;

endmodule

// File: tb/tb_brick_row.sv
// Bench for brick_row: vector table plus hand sequences; hits tracked by a timed scoreboard.
module tb_brick_row;

`ifdef BRICK_ROW_MULTIHIT_EN
  localparam int HITS = 3;
`else
  localparam int HITS = 1;
`endif
  localparam logic [24:0] NEVER = 25'h1FF_FFFF;

  logic       clk;
  logic       rst;
  logic [9:0] init_x, init_y, ball_x, ball_y;
  logic       ball_valid;
  logic [24:0] delay_done;
  logic [9:0] row_y;
  logic [7:0] alive;
  logic       busy, hit_pulse, cleared, game_over;
  logic [2:0] hit_idx;

  brick_row dut (
    .clk        (clk),
    .rst        (rst),
    .init_x     (init_x),
    .init_y     (init_y),
    .ball_x     (ball_x),
    .ball_y     (ball_y),
    .ball_valid (ball_valid),
    .delay_done (delay_done),
    .row_y      (row_y),
    .alive      (alive),
    .busy       (busy),
    .hit_pulse  (hit_pulse),
    .hit_idx    (hit_idx),
    .cleared    (cleared),
    .game_over  (game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int idx; int at; } exp_t;
  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Every hit_pulse must match the oldest expected hit, in index and in cycle.
  always @(negedge clk) begin : sb_mon
    exp_t e;
    if (rst === 1'b1 && hit_pulse === 1'b1) begin
      check("hit_expected", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("hit_idx_sb", 64'(hit_idx), 64'(e.idx));
        check("hit_cycle", 64'(cyc), 64'(e.at));
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input logic [9:0] y, input logic [24:0] d);
    rst        = 1'b0;
    init_y     = y;
    delay_done = d;
    ball_valid = 1'b0;
    tick(2);
    rst = 1'b1;
  endtask

  task automatic drive_ball(input logic [9:0] x, input logic [9:0] y, input int exp_idx);
    ball_x     = x;
    ball_y     = y;
    ball_valid = 1'b1;
    if (exp_idx >= 0) sb.push_back('{exp_idx, cyc + exp_idx + 2});
    tick();
    ball_valid = 1'b0;
  endtask

  typedef struct {
    logic [9:0] bx;
    logic [9:0] by;
    int         exp_idx;
    logic [7:0] exp_alive;
  } vec_t;
  vec_t vecs[8];

  initial begin
    int last_idx;
    int hcnt[8];
    logic [7:0] exp_alive;
    int idx;

    // Row at y=40, x=10 + 60*i; expected outcomes worked out by hand from the overlap rule.
`ifdef BRICK_ROW_MULTIHIT_EN
    vecs[0] = '{10'd140, 10'd45,  2, 8'hFF};
    vecs[1] = '{10'd0,   10'd300, -1, 8'hFF};
    vecs[2] = '{10'd140, 10'd45,  2, 8'hFF};
    vecs[3] = '{10'd440, 10'd50,  7, 8'hFF};
    vecs[4] = '{10'd0,   10'd0,   -1, 8'hFF};
    vecs[5] = '{10'd0,   10'd20,  0, 8'hFF};
    vecs[6] = '{10'd0,   10'd59,  0, 8'hFF};
    vecs[7] = '{10'd0,   10'd60,  -1, 8'hFF};
`else
    vecs[0] = '{10'd140, 10'd45,  2, 8'hFB};
    vecs[1] = '{10'd0,   10'd300, -1, 8'hFB};
    vecs[2] = '{10'd140, 10'd45,  3, 8'hF3};
    vecs[3] = '{10'd440, 10'd50,  7, 8'h73};
    vecs[4] = '{10'd0,   10'd0,   -1, 8'h73};
    vecs[5] = '{10'd0,   10'd20,  0, 8'h72};
    vecs[6] = '{10'd0,   10'd59,  1, 8'h70};
    vecs[7] = '{10'd0,   10'd60,  -1, 8'h70};
`endif

    init_x = 10'd10; ball_x = '0; ball_y = '0;

    // Reset state and descent cadence with delay_done=3.
    do_reset(10'd40, 25'd3);
    check("rst_row_y",     64'(row_y),     64'd40);
    check("rst_alive",     64'(alive),     64'hFF);
    check("rst_busy",      64'(busy),      64'd0);
    check("rst_hit_pulse", 64'(hit_pulse), 64'd0);
    check("rst_hit_idx",   64'(hit_idx),   64'd0);
    check("rst_cleared",   64'(cleared),   64'd0);
    check("rst_game_over", 64'(game_over), 64'd0);
    tick(3);
    check("desc_c3", 64'(row_y), 64'd40);
    tick();
    check("desc_c4", 64'(row_y), 64'd41);
    tick(3);
    check("desc_c7", 64'(row_y), 64'd41);
    tick();
    check("desc_c8", 64'(row_y), 64'd42);

    // Vector table.
    do_reset(10'd40, NEVER);
    last_idx = 0;
    for (int i = 0; i < 8; i++) begin
      drive_ball(vecs[i].bx, vecs[i].by, vecs[i].exp_idx);
      tick(11);
      if (vecs[i].exp_idx >= 0) last_idx = vecs[i].exp_idx;
      check($sformatf("vec%0d_busy", i),    64'(busy),    64'd0);
      check($sformatf("vec%0d_alive", i),   64'(alive),   64'(vecs[i].exp_alive));
      check($sformatf("vec%0d_hit_idx", i), 64'(hit_idx), 64'(last_idx));
    end

    // Miss: busy over cycles 1..8; a ball_valid at cycle 3 must be dropped.
    do_reset(10'd40, NEVER);
    drive_ball(10'd0, 10'd300, -1);
    for (int c = 1; c <= 10; c++) begin
      check($sformatf("miss_busy_c%0d", c), 64'(busy), 64'(c <= 8));
      if (c == 3) begin
        ball_x = 10'd140; ball_y = 10'd45; ball_valid = 1'b1;
      end else begin
        ball_valid = 1'b0;
      end
      tick();
    end
    check("miss_alive", 64'(alive), 64'hFF);

    // Hit at cycle 4 for brick 2; busy low at cycle 5.
    drive_ball(10'd140, 10'd45, 2);
    tick(3);
    check("hit2_busy_c4", 64'(busy), 64'd1);
    tick();
    check("hit2_busy_c5", 64'(busy), 64'd0);

    // Repeated hits at one spot; brick 2 falls after HITS strikes.
    do_reset(10'd40, NEVER);
    exp_alive = 8'hFF;
    for (int i = 0; i < 8; i++) hcnt[i] = 0;
    for (int h = 0; h < 3; h++) begin
      idx = (HITS == 1) ? 2 + h : 2;
      drive_ball(10'd140, 10'd45, idx);
      tick(11);
      hcnt[idx]++;
      if (hcnt[idx] == HITS) exp_alive[idx] = 1'b0;
      check($sformatf("multi%0d_alive", h), 64'(alive), 64'(exp_alive));
    end

    // Landing: row freezes at 439, game_over one cycle later, then balls are ignored.
    do_reset(10'd437, 25'd0);
    check("floor_c0", 64'(row_y), 64'd437);
    tick();
    check("floor_c1", 64'(row_y), 64'd438);
    tick();
    check("floor_c2", 64'(row_y), 64'd439);
    check("floor_go_c2", 64'(game_over), 64'd0);
    tick();
    check("floor_c3", 64'(row_y), 64'd439);
    check("floor_go_c3", 64'(game_over), 64'd1);
    drive_ball(10'd140, 10'd445, -1);
    check("floor_busy", 64'(busy), 64'd0);
    tick(12);
    check("floor_row_hold", 64'(row_y),     64'd439);
    check("floor_alive",    64'(alive),     64'hFF);
    check("floor_go_hold",  64'(game_over), 64'd1);
    check("floor_cleared",  64'(cleared),   64'd0);

    // Clear the whole row with a ball parked at x=0; lowest alive brick is taken each time.
    do_reset(10'd40, NEVER);
    for (int n = 0; n < 8 * HITS - 1; n++) begin
      drive_ball(10'd0, 10'd45, n / HITS);
      tick(11);
    end
    drive_ball(10'd0, 10'd45, 7);
    tick(9);
    check("clr_alive_c10",   64'(alive),   64'h00);
    check("clr_cleared_c10", 64'(cleared), 64'd0);
    tick();
    check("clr_cleared_c11", 64'(cleared),   64'd1);
    check("clr_go_c11",      64'(game_over), 64'd0);
    delay_done = 25'd0;
    tick(5);
    check("clr_row_frozen", 64'(row_y), 64'd40);
    drive_ball(10'd0, 10'd45, -1);
    check("clr_ignore_busy", 64'(busy), 64'd0);

    // Reset mid-scan discards the scan and reloads everything.
    do_reset(10'd40, NEVER);
    drive_ball(10'd140, 10'd45, 2);
    tick(11);
    ball_x = 10'd440; ball_y = 10'd50; ball_valid = 1'b1;
    tick();
    ball_valid = 1'b0;
    tick(2);
    check("mid_busy_before", 64'(busy), 64'd1);
    rst = 1'b0;
    init_y = 10'd41;
    tick();
    check("mid_row_y",     64'(row_y),     64'd41);
    check("mid_alive",     64'(alive),     64'hFF);
    check("mid_busy",      64'(busy),      64'd0);
    check("mid_hit_idx",   64'(hit_idx),   64'd0);
    check("mid_hit_pulse", 64'(hit_pulse), 64'd0);
    check("mid_cleared",   64'(cleared),   64'd0);
    check("mid_game_over", 64'(game_over), 64'd0);
    rst = 1'b1;
    tick(14);
    check("mid_after_busy", 64'(busy),    64'd0);
    check("mid_after_idx",  64'(hit_idx), 64'd0);

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
